// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window-fetch slice.
//   - Fetch FSM state encoding (3-bit)
//   - Default pixel width and kernel edge length
//   - Helpers for output-grid dimension and counter widths
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int FSM_W = 3;

    localparam logic [FSM_W-1:0] F_IDLE  = 3'd0;
    localparam logic [FSM_W-1:0] F_ISSUE = 3'd1;
    localparam logic [FSM_W-1:0] F_DRAIN = 3'd2;
    localparam logic [FSM_W-1:0] F_DONE  = 3'd3;
    localparam logic [FSM_W-1:0] F_WAIT  = 3'd4;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_K      = 3;

    // Number of valid window positions along one image dimension.
    function automatic int out_dim(input int img_dim, input int k);
        return img_dim - k + 1;
    endfunction

    // Counter width able to index n items; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// -----------------------------------------------------------------------------
// conv_pos_counter
// Output-position counters for the convolution window walk.
// Ports:
//   clk, rst_n           clock / asynchronous active-low reset
//   counter_enable_i     pulse: advance column, wrap into next row
//   addr_gen_i           pulse: clears the done flag
//   out_row_o            current output row (registered)
//   out_col_o            current output column (registered)
//   done_o               level: set after the last position wraps
// -----------------------------------------------------------------------------
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int ROW_W = cnt_w(IMG_H),
    parameter int COL_W = cnt_w(IMG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             counter_enable_i,
    input  logic             addr_gen_i,
    output logic [ROW_W-1:0] out_row_o,
    output logic [COL_W-1:0] out_col_o,
    output logic             done_o
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             done_q, done_d;
    logic             wrap_all_s;

    // Next position and done flag; a set on the final wrap beats an addr_gen clear.
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        wrap_all_s = counter_enable_i && (col_q == COL_LAST) && (row_q == ROW_LAST);
        if (counter_enable_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            col_d = col_q;
        end

        if (wrap_all_s) begin
            done_d = 1'b1;
        end else if (addr_gen_i) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // Position and done state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            done_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            done_q <= done_d;
        end
    end

    assign out_row_o = row_q;
    assign out_col_o = col_q;
    assign done_o    = done_q;

endmodule

// File: rtl/conv_window_fetch.sv
// -----------------------------------------------------------------------------
// conv_window_fetch
// Fetches the KxK pixel window at the current output position from a
// synchronous-read feature-map RAM into a register bank.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   addr_gen_i          pulse: latch window base address, abort any fetch
//   load_i              level: start a fetch; held until load_done_o
//   counter_enable_i    pulse: advance output position
//   load_done_o         pulse: window register bank complete
//   done_o              level: all output positions processed
//   mem_rd_en_o         RAM read strobe
//   mem_addr_o          RAM read address
//   mem_rdata_i         RAM read data, one cycle after mem_rd_en_o
//   win_flat_o          window; pixel (r,c) at [(r*K+c)*DATA_W +: DATA_W]
//   out_row_o/out_col_o current output position
// -----------------------------------------------------------------------------
module conv_window_fetch
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int K      = DEF_K,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     addr_gen_i,
    input  logic                     load_i,
    input  logic                     counter_enable_i,
    output logic                     load_done_o,
    output logic                     done_o,
    output logic                     mem_rd_en_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    output logic [K*K*DATA_W-1:0]    win_flat_o,
    output logic [cnt_w(IMG_H)-1:0]  out_row_o,
    output logic [cnt_w(IMG_W)-1:0]  out_col_o
);

    localparam int ROW_W  = cnt_w(IMG_H);
    localparam int COL_W  = cnt_w(IMG_W);
    localparam int KC_W   = cnt_w(K);
    localparam int SLOT_W = cnt_w(K * K);
    localparam int WIN_W  = K * K * DATA_W;

    localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
    localparam logic [KC_W-1:0]   K_LAST    = KC_W'(K - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(K * K - 1);

    // Position counters
    logic [ROW_W-1:0] out_row_s;
    logic [COL_W-1:0] out_col_s;
    logic             done_s;

    conv_pos_counter #(
        .K     (K),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_pos (
        .clk              (clk),
        .rst_n            (rst_n),
        .counter_enable_i (counter_enable_i),
        .addr_gen_i       (addr_gen_i),
        .out_row_o        (out_row_s),
        .out_col_o        (out_col_s),
        .done_o           (done_s)
    );

    // Fetch FSM and datapath state
    logic [FSM_W-1:0]  state_q, state_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              load_done_q, load_done_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [KC_W-1:0]   krow_q;
    logic [KC_W-1:0]   kcol_q;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] rd_slot_q;
    logic              rv_q;
    logic [WIN_W-1:0]  win_q;
    logic              last_issue_s;
    logic              issue_start_s;
    logic              issue_step_s;
    logic              capture_s;

    // The base uses the position before any same-cycle counter update.
    assign base_s = ADDR_W'(out_row_s) * IMG_W_A + ADDR_W'(out_col_s);

    // Fetch FSM state and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= F_IDLE;
            mem_rd_en_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_rd_en_q <= mem_rd_en_d;
            load_done_q <= load_done_d;
        end
    end

    // Fetch FSM next state; addr_gen aborts from any state.
    always_comb begin
        state_d      = state_q;
        last_issue_s = (krow_q == K_LAST) && (kcol_q == K_LAST);
        if (addr_gen_i) begin
            state_d = F_IDLE;
        end else begin
            case (state_q)
                F_IDLE: begin
                    if (load_i) begin
                        state_d = F_ISSUE;
                    end else begin
                        state_d = F_IDLE;
                    end
                end
                F_ISSUE: begin
                    if (last_issue_s) begin
                        state_d = F_DRAIN;
                    end else begin
                        state_d = F_ISSUE;
                    end
                end
                F_DRAIN: begin
                    if (rv_q && (rd_slot_q == SLOT_LAST)) begin
                        state_d = F_DONE;
                    end else begin
                        state_d = F_DRAIN;
                    end
                end
                F_DONE: begin
                    state_d = F_WAIT;
                end
                F_WAIT: begin
                    // Controller may still hold load in its exit cycle.
                    if (!load_i) begin
                        state_d = F_IDLE;
                    end else begin
                        state_d = F_WAIT;
                    end
                end
                default: begin
                    state_d = F_IDLE;
                end
            endcase
        end
    end

    // Fetch FSM outputs, derived from the next state so they register cleanly.
    always_comb begin
        mem_rd_en_d   = (state_d == F_ISSUE);
        load_done_d   = (state_d == F_DONE);
        issue_start_s = (state_q == F_IDLE) && (state_d == F_ISSUE);
        issue_step_s  = (state_q == F_ISSUE) && (state_d == F_ISSUE);
        capture_s     = rv_q && !addr_gen_i;
    end

    // Base latch, read address walk and read-valid pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            mem_addr_q <= '0;
            row_base_q <= '0;
            krow_q     <= '0;
            kcol_q     <= '0;
            slot_q     <= '0;
            rd_slot_q  <= '0;
            rv_q       <= 1'b0;
        end else begin
            if (addr_gen_i) begin
                base_q <= base_s;
            end
            if (issue_start_s) begin
                mem_addr_q <= base_q;
                row_base_q <= base_q;
                krow_q     <= '0;
                kcol_q     <= '0;
                slot_q     <= '0;
            end else if (issue_step_s) begin
                slot_q <= slot_q + SLOT_W'(1);
                if (kcol_q == K_LAST) begin
                    // Next row: add the image stride to the row base, no multiply.
                    kcol_q     <= '0;
                    krow_q     <= krow_q + KC_W'(1);
                    row_base_q <= row_base_q + IMG_W_A;
                    mem_addr_q <= row_base_q + IMG_W_A;
                end else begin
                    kcol_q     <= kcol_q + KC_W'(1);
                    mem_addr_q <= mem_addr_q + ADDR_W'(1);
                end
            end
            // Reads already in flight when a fetch is aborted are discarded.
            rv_q      <= mem_rd_en_q && !addr_gen_i;
            rd_slot_q <= slot_q;
        end
    end

    // Window register bank; only written when read data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else begin
            for (int i = 0; i < K * K; i++) begin
                if (capture_s && (rd_slot_q == SLOT_W'(i))) begin
                    win_q[i*DATA_W +: DATA_W] <= mem_rdata_i;
                end
            end
        end
    end

    assign load_done_o = load_done_q;
    assign done_o      = done_s;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign win_flat_o  = win_q;
    assign out_row_o   = out_row_s;
    assign out_col_o   = out_col_s;

endmodule

// File: tb/tb_conv_window_fetch.sv
// -----------------------------------------------------------------------------
// tb_conv_window_fetch
// Self-checking bench: 5x5 image, K=3, RAM[i]=i. Expected read addresses are
// queued when a fetch is launched and popped as the DUT issues reads.
// -----------------------------------------------------------------------------
module tb_conv_window_fetch;

    localparam int DATA_W = 8;
    localparam int K      = 3;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int ADDR_W = 10;
    localparam int WIN_W  = K * K * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              addr_gen;
    logic              load;
    logic              counter_enable;
    logic              load_done;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [WIN_W-1:0]  win_flat;
    logic [2:0]        out_row;
    logic [2:0]        out_col;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W-1:0] exp_q[$];

    conv_window_fetch #(
        .DATA_W (DATA_W),
        .K      (K),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .addr_gen_i       (addr_gen),
        .load_i           (load),
        .counter_enable_i (counter_enable),
        .load_done_o      (load_done),
        .done_o           (done),
        .mem_rd_en_o      (mem_rd_en),
        .mem_addr_o       (mem_addr),
        .mem_rdata_i      (mem_rdata),
        .win_flat_o       (win_flat),
        .out_row_o        (out_row),
        .out_col_o        (out_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model with RAM[i] = i.
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_addr[DATA_W-1:0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIN_W-1:0] exp_win(input int base);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < K * K; i++)
            w[i*DATA_W +: DATA_W] = DATA_W'(base + (i / K) * IMG_W + (i % K));
        return w;
    endfunction

    // Drives a one-cycle pulse; returns at the negedge after the sampling edge.
    task automatic pulse(input logic ag, input logic ce);
        addr_gen       = ag;
        counter_enable = ce;
        @(negedge clk);
        addr_gen       = 1'b0;
        counter_enable = 1'b0;
    endtask

    // Full fetch from the latched base, optionally holding load after load_done.
    task automatic run_fetch(input int base, input int hold, input string tag);
        logic exp_rd;
        logic [ADDR_W-1:0] ea;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                exp_q.push_back(ADDR_W'(base + r * IMG_W + c));
        load = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            exp_rd = (k <= K * K);
            checks++;
            if (mem_rd_en !== exp_rd) begin
                errors++;
                $display("FAIL %s rd_en k=%0d: got %b want %b", tag, k, mem_rd_en, exp_rd);
            end
            if (mem_rd_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s addr k=%0d: got %0d want none", tag, k, mem_addr);
                end else begin
                    ea = exp_q.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL %s addr k=%0d: got %0d want %0d", tag, k, mem_addr, ea);
                    end
                end
            end
            checks++;
            if (load_done !== (k == 11)) begin
                errors++;
                $display("FAIL %s load_done k=%0d: got %b want %b", tag, k, load_done, (k == 11));
            end
        end
        checks++;
        if (win_flat !== exp_win(base)) begin
            errors++;
            $display("FAIL %s win_flat: got %h want %h", tag, win_flat, exp_win(base));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (mem_rd_en !== 1'b0 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL %s hold h=%0d: got rd_en=%b load_done=%b want 0 0", tag, h, mem_rd_en, load_done);
            end
        end
        load = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (mem_rd_en !== 1'b0 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL %s after: got rd_en=%b load_done=%b want 0 0", tag, mem_rd_en, load_done);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s addr_count: got %0d left want 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr_gen = 1'b0; load = 1'b0; counter_enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b0 || load_done !== 1'b0 || done !== 1'b0 ||
            out_row !== 3'd0 || out_col !== 3'd0 || win_flat !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset: got rd_en=%b ld=%b done=%b row=%0d col=%0d addr=%0d win=%h want all 0",
                     mem_rd_en, load_done, done, out_row, out_col, mem_addr, win_flat);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        pulse(1'b1, 1'b0);
        run_fetch(0, 0, "single");
    endtask

    task automatic test_sweep();
        int erow, ecol;
        for (int p = 0; p < 9; p++) begin
            pulse(1'b1, 1'b0);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL sweep done_early p=%0d: got %b want 0", p, done);
            end
            run_fetch((p / 3) * IMG_W + (p % 3), 0, "sweep");
            pulse(1'b0, 1'b1);
            erow = ((p + 1) % 9) / 3;
            ecol = ((p + 1) % 9) % 3;
            checks++;
            if (out_row !== 3'(erow) || out_col !== 3'(ecol) || done !== (p == 8)) begin
                errors++;
                $display("FAIL sweep pos p=%0d: got (%0d,%0d) done=%b want (%0d,%0d) done=%b",
                         p, out_row, out_col, done, erow, ecol, (p == 8));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL sweep done_hold: got %b want 1", done);
        end
        pulse(1'b1, 1'b0);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL sweep done_clear: got %b want 0", done);
        end
    endtask

    task automatic test_load_hold();
        pulse(1'b1, 1'b0);
        run_fetch(0, 3, "hold");
        // A fresh request after load dropped must fetch again.
        run_fetch(0, 0, "refetch");
    endtask

    task automatic test_simultaneous();
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        checks++;
        if (out_row !== 3'd1 || out_col !== 3'd0) begin
            errors++;
            $display("FAIL simul pos: got (%0d,%0d) want (1,0)", out_row, out_col);
        end
        run_fetch(2, 0, "simul");
    endtask

    task automatic test_abort();
        logic [ADDR_W-1:0] ea;
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        exp_q.push_back(10'd6); exp_q.push_back(10'd7);
        exp_q.push_back(10'd8); exp_q.push_back(10'd11);
        load = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            addr_gen = 1'b0;
            checks++;
            if (mem_rd_en !== (k <= 4) || load_done !== 1'b0) begin
                errors++;
                $display("FAIL abort k=%0d: got rd_en=%b ld=%b want %b 0", k, mem_rd_en, load_done, (k <= 4));
            end
            if (mem_rd_en === 1'b1 && exp_q.size() != 0) begin
                ea = exp_q.pop_front();
                checks++;
                if (mem_addr !== ea) begin
                    errors++;
                    $display("FAIL abort addr k=%0d: got %0d want %0d", k, mem_addr, ea);
                end
            end
            if (k == 4) begin
                addr_gen = 1'b1;
                load     = 1'b0;
            end
        end
        exp_q.delete();
        run_fetch(6, 0, "post_abort");
    endtask

    task automatic test_reset_mid();
        pulse(1'b1, 1'b0);
        load = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_rd_en !== 1'b0 || load_done !== 1'b0 || done !== 1'b0 ||
            out_row !== 3'd0 || out_col !== 3'd0 || win_flat !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rd_en=%b ld=%b done=%b row=%0d col=%0d win=%h want all 0",
                     mem_rd_en, load_done, done, out_row, out_col, win_flat);
        end
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(1'b1, 1'b0);
        run_fetch(0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_sweep();
        test_load_hold();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Stage directly upstream of the convolution control FSM.
- Owns the output-position counters: row and column of the current window's top-left pixel.
- On `addr_gen` it computes the window base address. On `load` it reads the K×K pixel window from a synchronous-read feature-map RAM into a register bank, then pulses `load_done`.
- On `counter_enable` it advances the position and raises `done` after the last output position.

Parameters:
- DATA_W, 8, pixel width in bits.
- K, 3, kernel/window edge length.
- IMG_W, 28, input image width in pixels.
- IMG_H, 28, input image height in pixels.
- ADDR_W, 10, feature-map RAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr_gen  in  1  one-cycle pulse: latch base address for current position, clear `done`.
- load  in  1  level, held by controller until `load_done` is seen: start/continue window fetch.
- counter_enable  in  1  one-cycle pulse: advance output position.
- load_done  out  1  one-cycle pulse: window register bank is complete.
- done  out  1  level: all output positions processed.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after `mem_rd_en`.
- win_flat  out  K*K*DATA_W  window pixels; pixel (r,c) at bits [(r*K+c)*DATA_W +: DATA_W].
- out_row  out  $clog2(IMG_H)  current output row.
- out_col  out  $clog2(IMG_W)  current output column.

Behaviour:
- Reset values: all outputs 0, `win_flat` 0, counters 0, fetch FSM in F_IDLE.
  - Reset is asynchronous and may arrive mid-fetch; on release, state is as after a cold reset.
- Output grid: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1.
- Position counters, on `counter_enable`:
  - `out_col` increments.
  - At OUT_W-1, `out_col` wraps to 0 and `out_row` increments.
  - At (OUT_H-1, OUT_W-1), both wrap to 0 and `done` is set (registered, visible the next cycle).
- `done` is a level: it stays high until the next `addr_gen`, which clears it.
- `addr_gen`:
  - Registers base = out_row*IMG_W + out_col, using an ADDR_W-bit product.
  - Aborts any fetch in progress; the FSM returns to F_IDLE and `load_done` is not issued.
- Fetch FSM states: F_IDLE, F_ISSUE, F_DRAIN, F_DONE, F_WAIT.
  - F_IDLE: `load`=1 at cycle T → F_ISSUE.
  - F_ISSUE: registered reads are issued in cycles T+1..T+K*K, i.e. T+1..T+9 for K=3.
    - Order is row-major; the address is base + r*IMG_W + c.
    - Use an incrementing row-base register plus a column offset; no multiplier in this path.
    - After the last issue → F_DRAIN.
  - F_DRAIN: `mem_rdata` is captured into window slot r*K+c in cycles T+2..T+K*K+1, tracked by a 1-cycle read-valid pipe → F_DONE.
  - F_DONE: `load_done`=1 for exactly one cycle (T+K*K+2 = T+11 for K=3); `win_flat` is stable from this cycle → F_WAIT.
  - F_WAIT: stay until `load`=0, then F_IDLE. This prevents a re-fetch while the controller still holds `load` in its exit cycle.
- Dropping `load` during F_ISSUE/F_DRAIN does not stop the fetch: it completes and `load_done` is still pulsed.
- `win_flat` changes only on data capture and holds between fetches; the MAC stages depend on it being stable.
- Simultaneous `counter_enable` and `addr_gen`: the counter update wins for the counters. The base address uses the pre-update position.
- `counter_enable` while the fetch FSM is not in F_IDLE: counters advance; the fetch continues with its latched base.
- `mem_rd_en` is high only in F_ISSUE cycles; `mem_addr` holds its last value otherwise.

Decomposition:
- Shared package `conv_pkg`:
  - Fetch FSM state encoding (3-bit localparams).
  - Default DATA_W and K.
  - Function for OUT_W/OUT_H.
- One sub-module, `conv_pos_counter`: row/column counters with wrap, the `done` flag, and the `addr_gen` clear.
- Base-address computation and the fetch FSM stay in the top module.

Test Plan:
- Run every test with IMG_W=5, IMG_H=5, K=3 and RAM[i]=i; OUT grid is 3×3.
- Single fetch at (0,0):
  - Stimulus: `addr_gen` pulse, then `load` held from cycle T.
  - Required: `mem_addr` sequence 0,1,2,5,6,7,10,11,12 in cycles T+1..T+9; `load_done` exactly at T+11.
  - Required: `win_flat` = {12,11,10,7,6,5,2,1,0}, MSB slot first.
- Position sweep:
  - Stimulus: 9 × (`addr_gen`, fetch, `counter_enable`).
  - Required: bases 0,1,2,5,6,7,10,11,12.
  - Required: `done` rises only the cycle after the 9th `counter_enable`; counters read (0,0).
  - Required: the next `addr_gen` clears `done`.
- Load held after `load_done`:
  - Stimulus: keep `load`=1 for 3 extra cycles.
  - Required: no new `mem_rd_en`, no second `load_done`; F_IDLE re-entered only after `load`=0.
- Abort:
  - Stimulus: `addr_gen` at T+4 of a fetch at position (1,1).
  - Required: no `load_done` from that fetch.
  - Required: a fresh `load` yields addresses 6,7,8,11,12,13,16,17,18.
- Reset mid-fetch:
  - Stimulus: assert `rst_n`=0 asynchronously at T+5.
  - Required: `mem_rd_en`, `load_done`, `done`, counters and `win_flat` are 0 immediately.
  - Required: after release, a normal fetch at (0,0) passes.
- Simultaneous `counter_enable` and `addr_gen` at (0,2):
  - Required: latched base = 2; counters go to (1,0).
